// File: rtl/modsq_iteration_ctrl.sv
// Iteration sequencer for VDF modular squaring: loads x, issues T squarings through an
// external squarer with a per-squaring watchdog, and returns x^(2^T) in redundant form.
module modsq_iteration_ctrl #(
  parameter int unsigned MOD_LEN        = 1024,
  parameter int unsigned WORD_LEN       = 16,
  parameter int unsigned BIT_LEN        = 17,
  parameter int unsigned NUM_ELEMENTS   = MOD_LEN / WORD_LEN + 2,
  parameter int unsigned T_WIDTH        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [MOD_LEN-1:0]              cmd_x,
  input  logic [T_WIDTH-1:0]              cmd_t,
  input  logic                            abort,
  output logic                            msq_start,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] msq_sq_in,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] msq_sq_out,
  input  logic                            msq_valid,
  output logic                            busy,
  output logic [T_WIDTH-1:0]              iter_count,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] res_sq,
  output logic                            res_timeout
);

  localparam int unsigned SQ_W      = NUM_ELEMENTS * BIT_LEN;
  localparam int unsigned NUM_WORDS = MOD_LEN / WORD_LEN;
  localparam int unsigned WD_W      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SQ_W-1:0]    r_operand, w_operand_nxt;
  logic [T_WIDTH-1:0] r_t, w_t_nxt;
  logic [T_WIDTH-1:0] r_iter, w_iter_nxt;
  logic [T_WIDTH-1:0] w_iter_inc;
  logic [WD_W-1:0]    r_wdog, w_wdog_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [SQ_W-1:0]    w_split;

  // Spread x into nonredundant coefficients; redundant top coefficients stay zero.
  always_comb begin
    w_split = '0;
    for (int j = 0; j < NUM_WORDS; j++) begin
      w_split[j*BIT_LEN +: BIT_LEN] = BIT_LEN'(cmd_x[j*WORD_LEN +: WORD_LEN]);
    end
  end

  assign w_iter_inc = r_iter + T_WIDTH'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_operand_nxt = r_operand;
    w_t_nxt       = r_t;
    w_iter_nxt    = r_iter;
    w_wdog_nxt    = r_wdog;
    w_timeout_nxt = r_timeout;
    if (abort && (r_state != ST_IDLE)) begin
      // abort outranks any concurrent valid, expiry or result handshake
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            w_operand_nxt = w_split;
            w_t_nxt       = cmd_t;
            w_iter_nxt    = '0;
            w_timeout_nxt = 1'b0;
            w_state_nxt   = (cmd_t == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          w_wdog_nxt  = WD_W'(TIMEOUT_CYCLES);
          w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          w_wdog_nxt = (r_wdog != '0) ? r_wdog - WD_W'(1) : '0;
          if (msq_valid) begin
            w_operand_nxt = msq_sq_out;
            w_iter_nxt    = w_iter_inc;
            w_state_nxt   = (w_iter_inc == r_t) ? ST_DONE : ST_ISSUE;
          end else if (r_wdog <= WD_W'(1)) begin
            // this cycle's decrement drains the watchdog
            w_timeout_nxt = 1'b1;
            w_state_nxt   = ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_operand <= '0;
      r_t       <= '0;
      r_iter    <= '0;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_operand <= w_operand_nxt;
      r_t       <= w_t_nxt;
      r_iter    <= w_iter_nxt;
      r_wdog    <= w_wdog_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign msq_start   = (r_state == ST_ISSUE);
  assign res_valid   = (r_state == ST_DONE);
  assign msq_sq_in   = r_operand;
  assign res_sq      = r_operand;
  assign iter_count  = r_iter;
  assign res_timeout = r_timeout;

endmodule

// File: tb/tb_modsq_iteration_ctrl.sv
// Bench for modsq_iteration_ctrl: stub squarer with programmable latency, expected results
// queued at command time and checked when the result appears.
module tb_modsq_iteration_ctrl;

  localparam int unsigned MOD_LEN  = 64;
  localparam int unsigned WORD_LEN = 16;
  localparam int unsigned BIT_LEN  = 17;
  localparam int unsigned NUM_EL   = MOD_LEN / WORD_LEN + 2;
  localparam int unsigned T_W      = 64;
  localparam int unsigned TO       = 16;
  localparam int unsigned SQ_W     = NUM_EL * BIT_LEN;

  typedef struct {
    logic [SQ_W-1:0] sq;
    logic            to;
    logic [T_W-1:0]  iter;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0, cmd_ready;
  logic [MOD_LEN-1:0] cmd_x = '0;
  logic [T_W-1:0]     cmd_t = '0;
  logic               abort = 1'b0;
  logic               msq_start;
  logic [SQ_W-1:0]    msq_sq_in;
  logic [SQ_W-1:0]    msq_sq_out = '0;
  logic               msq_valid = 1'b0;
  logic               busy;
  logic [T_W-1:0]     iter_count;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [SQ_W-1:0]    res_sq;
  logic               res_timeout;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int stub_lat = 0, stub_cnt = 0, n_start = 0, n_valid = 0, abort_at = 0;
  int accept_cyc = 0, first_start_cyc = 0, last_valid_cyc = 0, gap_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  modsq_iteration_ctrl #(
    .MOD_LEN(MOD_LEN), .WORD_LEN(WORD_LEN), .BIT_LEN(BIT_LEN), .NUM_ELEMENTS(NUM_EL),
    .T_WIDTH(T_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x),
    .cmd_t(cmd_t), .abort(abort), .msq_start(msq_start), .msq_sq_in(msq_sq_in),
    .msq_sq_out(msq_sq_out), .msq_valid(msq_valid), .busy(busy), .iter_count(iter_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_sq(res_sq), .res_timeout(res_timeout)
  );

  function automatic logic [SQ_W-1:0] split(input logic [MOD_LEN-1:0] x);
    logic [SQ_W-1:0] r;
    r = '0;
    for (int j = 0; j < int'(MOD_LEN / WORD_LEN); j++)
      r[j*BIT_LEN +: BIT_LEN] = BIT_LEN'(x[j*WORD_LEN +: WORD_LEN]);
    return r;
  endfunction

  // Plain integer square of the coefficient vector, re-split into words.
  function automatic logic [SQ_W-1:0] square(input logic [SQ_W-1:0] c);
    logic [127:0] v, s;
    logic [SQ_W-1:0] r;
    v = '0;
    r = '0;
    for (int j = 0; j < int'(NUM_EL); j++)
      v = v + (128'(c[j*BIT_LEN +: BIT_LEN]) << (WORD_LEN * j));
    s = v * v;
    for (int j = 0; j < int'(NUM_EL); j++)
      r[j*BIT_LEN +: BIT_LEN] = BIT_LEN'(s[j*WORD_LEN +: WORD_LEN]);
    return r;
  endfunction

  // One clock; sample just after the edge and run the stub squarer.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    msq_valid = 1'b0;
    abort     = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        msq_valid  = 1'b1;
        msq_sq_out = square(msq_sq_in);
        n_valid++;
        last_valid_cyc = cyc;
        if (n_valid == abort_at) abort = 1'b1;
      end
    end
    if (msq_start === 1'b1) begin
      n_start++;
      if (n_start == 1) first_start_cyc = cyc;
      if ((n_start == 1) ? (cyc != accept_cyc + 1) : (cyc != last_valid_cyc + 1)) gap_err++;
      if (stub_lat > 0) stub_cnt = stub_lat;
    end
  endtask

  task automatic send_cmd(input logic [MOD_LEN-1:0] x, input logic [T_W-1:0] t);
    n_start = 0; n_valid = 0; gap_err = 0; last_valid_cyc = -10; stub_cnt = 0;
    cmd_x = x; cmd_t = t; cmd_valid = 1'b1;
    accept_cyc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({cmd_ready, busy, msq_start, res_valid, res_timeout} !== 5'b10000) begin
      $display("FAIL reset_flags: got %b required 10000",
               {cmd_ready, busy, msq_start, res_valid, res_timeout}); n_fail++;
    end
    n_cmp++;
    if (iter_count !== '0) begin
      $display("FAIL reset_iter: got %0d required 0", iter_count); n_fail++;
    end
    n_cmp++;
    if (msq_sq_in !== '0) begin
      $display("FAIL reset_sq_in: got %h required 0", msq_sq_in); n_fail++;
    end
    n_cmp++;
    if (res_sq !== '0) begin
      $display("FAIL reset_res_sq: got %h required 0", res_sq); n_fail++;
    end
  endtask

  task automatic test_t_zero();
    exp_t e;
    stub_lat = 5;
    exp_q.push_back('{sq: split(64'h1234), to: 1'b0, iter: '0});
    send_cmd(64'h1234, '0);
    n_cmp++;
    if (res_valid !== 1'b1) begin
      $display("FAIL t0_latency: res_valid=%b one cycle after accept, required 1", res_valid); n_fail++;
    end
    wait_res(4);
    e = exp_q.pop_front();
    n_cmp++;
    if (res_sq !== e.sq || res_timeout !== e.to || iter_count !== e.iter) begin
      $display("FAIL t0_result: got sq=%h to=%b it=%0d required sq=%h to=%b it=%0d",
               res_sq, res_timeout, iter_count, e.sq, e.to, e.iter); n_fail++;
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    n_cmp++;
    if (n_start != 0 || cmd_ready !== 1'b1) begin
      $display("FAIL t0_idle: starts=%0d cmd_ready=%b required 0 and 1", n_start, cmd_ready); n_fail++;
    end
  endtask

  task automatic test_squaring();
    exp_t e;
    stub_lat = 5;
    exp_q.push_back('{sq: split(64'd6561), to: 1'b0, iter: T_W'(3)});
    send_cmd(64'd3, T_W'(3));
    wait_res(200);
    n_cmp++;
    if (res_valid !== 1'b1) begin
      $display("FAIL sq_wait: res_valid=%b required 1", res_valid); n_fail++;
    end
    n_cmp++;
    if (n_start != 3 || gap_err != 0) begin
      $display("FAIL sq_starts: starts=%0d gap_errors=%0d required 3 and 0", n_start, gap_err); n_fail++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (res_sq !== e.sq || res_timeout !== e.to || iter_count !== e.iter) begin
      $display("FAIL sq_result: got sq=%h to=%b it=%0d required sq=%h to=%b it=%0d",
               res_sq, res_timeout, iter_count, e.sq, e.to, e.iter); n_fail++;
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      $display("FAIL sq_idle: cmd_ready=%b res_valid=%b required 1 and 0", cmd_ready, res_valid); n_fail++;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    stub_lat = 0;
    exp_q.push_back('{sq: split(64'h55), to: 1'b1, iter: '0});
    send_cmd(64'h55, T_W'(2));
    wait_res(100);
    n_cmp++;
    if (res_valid !== 1'b1 || cyc - first_start_cyc != 17) begin
      $display("FAIL to_latency: res_valid=%b at %0d cycles after start, required 1 at 17",
               res_valid, cyc - first_start_cyc); n_fail++;
    end
    n_cmp++;
    if (n_start != 1) begin
      $display("FAIL to_starts: got %0d required 1", n_start); n_fail++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (res_sq !== e.sq || res_timeout !== e.to || iter_count !== e.iter) begin
      $display("FAIL to_result: got sq=%h to=%b it=%0d required sq=%h to=%b it=%0d",
               res_sq, res_timeout, iter_count, e.sq, e.to, e.iter); n_fail++;
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL to_idle: cmd_ready=%b required 1", cmd_ready); n_fail++;
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int n, seen;
    stub_lat = 3;
    abort_at = 2;
    send_cmd(64'd2, T_W'(5));
    n = 0;
    while (n_valid < 2 && n < 100) begin tick(); n++; end
    abort_at = 0;
    n_cmp++;
    if (n_valid < 2) begin
      $display("FAIL ab_wait: valids=%0d required 2", n_valid); n_fail++;
    end
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || iter_count !== T_W'(1)) begin
      $display("FAIL ab_idle: rdy=%b busy=%b rv=%b it=%0d required 1 0 0 1",
               cmd_ready, busy, res_valid, iter_count); n_fail++;
    end
    msq_valid = 1'b1;
    msq_sq_out = split(64'hDEAD);
    tick();
    n_cmp++;
    if (iter_count !== T_W'(1) || msq_sq_in !== split(64'd4)) begin
      $display("FAIL ab_late_valid: it=%0d sq_in=%h required 1 and %h",
               iter_count, msq_sq_in, split(64'd4)); n_fail++;
    end
    seen = 0;
    repeat (5) begin tick(); if (res_valid !== 1'b0) seen++; end
    n_cmp++;
    if (seen != 0) begin
      $display("FAIL ab_no_result: res_valid high %0d cycles required 0", seen); n_fail++;
    end
    exp_q.push_back('{sq: split(64'd25), to: 1'b0, iter: T_W'(1)});
    send_cmd(64'd5, T_W'(1));
    wait_res(100);
    e = exp_q.pop_front();
    n_cmp++;
    if (res_valid !== 1'b1 || res_sq !== e.sq || res_timeout !== e.to || iter_count !== e.iter) begin
      $display("FAIL ab_next_job: rv=%b sq=%h to=%b it=%0d required 1 %h %b %0d",
               res_valid, res_sq, res_timeout, iter_count, e.sq, e.to, e.iter); n_fail++;
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    stub_lat = 2;
    exp_q.push_back('{sq: split(64'd49), to: 1'b0, iter: T_W'(1)});
    send_cmd(64'd7, T_W'(1));
    wait_res(100);
    e = exp_q.pop_front();
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (res_valid !== 1'b1 || res_sq !== e.sq || cmd_ready !== 1'b0) begin
        $display("FAIL bp_hold%0d: rv=%b sq=%h rdy=%b required 1 %h 0",
                 k, res_valid, res_sq, cmd_ready, e.sq); n_fail++;
      end
      if (k < 6) tick();
    end
    n_cmp++;
    if (res_timeout !== e.to || iter_count !== e.iter) begin
      $display("FAIL bp_status: to=%b it=%0d required %b %0d", res_timeout, iter_count, e.to, e.iter); n_fail++;
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL bp_idle: rdy=%b busy=%b required 1 0", cmd_ready, busy); n_fail++;
    end
  endtask

  task automatic test_reset_mid_wait();
    stub_lat = 0;
    send_cmd(64'h99, T_W'(2));
    repeat (4) tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL rw_busy: busy=%b required 1", busy); n_fail++;
    end
    #2;
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({cmd_ready, busy, msq_start, res_valid, res_timeout} !== 5'b10000 ||
        iter_count !== '0 || msq_sq_in !== '0 || res_sq !== '0) begin
      $display("FAIL rw_async: flags=%b it=%0d sq_in=%h res_sq=%h required 10000 0 0 0",
               {cmd_ready, busy, msq_start, res_valid, res_timeout}, iter_count, msq_sq_in, res_sq);
      n_fail++;
    end
    @(negedge clk);
    reset = 1'b0;
    msq_valid = 1'b1;
    msq_sq_out = split(64'hBEEF);
    tick();
    n_cmp++;
    if (iter_count !== '0 || msq_sq_in !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL rw_ignore_valid: it=%0d sq_in=%h busy=%b rdy=%b required 0 0 0 1",
               iter_count, msq_sq_in, busy, cmd_ready); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_t_zero();
    test_squaring();
    test_timeout();
    test_abort();
    test_backpressure();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
